// File: rtl/dec_pkg.sv
// Shared types and constants for the decryption job controller.
package dec_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StFill,
        StShift,
        StRun,
        StFin
    } state_e;

    localparam logic [1:0]  MODE_EN   = 2'b01;
    localparam logic [1:0]  MODE_BF   = 2'b10;
    localparam logic [4:0]  SHIFT_REG = 5'd6;
    localparam int unsigned BUF_BASE  = 1500;
    localparam int unsigned BUF_LEN   = 108;

    function automatic logic mode_valid(input logic [1:0] mode);
        return (mode == MODE_EN) || (mode == MODE_BF);
    endfunction

endpackage

// File: rtl/decrypt_job_ctrl_if.sv
// Host, processor and memory-port signals of the job controller; slave is the controller side.
interface decrypt_job_ctrl_if;

    logic        start;
    logic [1:0]  mode;
    logic [4:0]  shift_amt;
    logic        ch_valid;
    logic        ch_ready;
    logic [7:0]  ch_data;
    logic        ch_last;
    logic        cpu_mwe;
    logic [11:0] cpu_maddr;
    logic [31:0] cpu_mdata;
    logic        cpu_rwe;
    logic [4:0]  cpu_rd;
    logic [31:0] cpu_rdata;
    logic        ram_wen;
    logic [11:0] ram_addr;
    logic [31:0] ram_din;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata;
    logic        cpu_reset;
    logic [1:0]  program_sel;
    logic        busy;
    logic        done;
    logic        timeout;
    logic        err;

    modport master (
        output start, mode, shift_amt, ch_valid, ch_data, ch_last,
        output cpu_mwe, cpu_maddr, cpu_mdata, cpu_rwe, cpu_rd, cpu_rdata,
        input  ch_ready, ram_wen, ram_addr, ram_din, rf_we, rf_rd, rf_wdata,
        input  cpu_reset, program_sel, busy, done, timeout, err
    );

    modport slave (
        input  start, mode, shift_amt, ch_valid, ch_data, ch_last,
        input  cpu_mwe, cpu_maddr, cpu_mdata, cpu_rwe, cpu_rd, cpu_rdata,
        output ch_ready, ram_wen, ram_addr, ram_din, rf_we, rf_rd, rf_wdata,
        output cpu_reset, program_sel, busy, done, timeout, err
    );

endinterface

// File: rtl/port_arbiter.sv
// Combinational mux of the controller and processor RAM/regfile write ports.
module port_arbiter (
    input  logic        in_run_i,
    input  logic        ctl_ram_wen_i,
    input  logic [11:0] ctl_ram_addr_i,
    input  logic [31:0] ctl_ram_din_i,
    input  logic        ctl_rf_we_i,
    input  logic [4:0]  ctl_rf_rd_i,
    input  logic [31:0] ctl_rf_wdata_i,
    input  logic        cpu_mwe_i,
    input  logic [11:0] cpu_maddr_i,
    input  logic [31:0] cpu_mdata_i,
    input  logic        cpu_rwe_i,
    input  logic [4:0]  cpu_rd_i,
    input  logic [31:0] cpu_rdata_i,
    output logic        ram_wen_o,
    output logic [11:0] ram_addr_o,
    output logic [31:0] ram_din_o,
    output logic        rf_we_o,
    output logic [4:0]  rf_rd_o,
    output logic [31:0] rf_wdata_o
);

    always_comb begin
        if (in_run_i) begin
            ram_wen_o  = cpu_mwe_i;
            ram_addr_o = cpu_maddr_i;
            ram_din_o  = cpu_mdata_i;
            rf_we_o    = cpu_rwe_i;
            rf_rd_o    = cpu_rd_i;
            rf_wdata_o = cpu_rdata_i;
        end else begin
            ram_wen_o  = ctl_ram_wen_i;
            ram_addr_o = ctl_ram_addr_i;
            ram_din_o  = ctl_ram_din_i;
            rf_we_o    = ctl_rf_we_i;
            rf_rd_o    = ctl_rf_rd_i;
            rf_wdata_o = ctl_rf_wdata_i;
        end
    end

endmodule

// File: rtl/decrypt_job_ctrl.sv
// Job sequencer: loads the character buffer, zero-fills, injects the shift, runs the processor.
module decrypt_job_ctrl
    import dec_pkg::*;
#(
    parameter int unsigned BUF_BASE   = dec_pkg::BUF_BASE,
    parameter int unsigned BUF_LEN    = dec_pkg::BUF_LEN,
    parameter logic [11:0] DONE_ADDR  = 12'hFFF,
    parameter int unsigned MAX_CYCLES = 5000
) (
    input logic               clock_i,
    input logic               reset_ni,
    decrypt_job_ctrl_if.slave bus
);

    localparam int unsigned     CntW     = $clog2(MAX_CYCLES + 1);
    localparam logic [6:0]      IdxLast  = 7'(BUF_LEN - 1);
    localparam logic [11:0]     BaseAddr = 12'(BUF_BASE);
    localparam logic [CntW-1:0] CycLast  = CntW'(MAX_CYCLES - 1);

    state_e          state_q, state_d;
    logic [1:0]      mode_q, mode_d;
    logic [4:0]      shift_q, shift_d;
    logic [6:0]      idx_q, idx_d;
    logic [CntW-1:0] cyc_q, cyc_d;
    logic            run_q, run_d;
    logic            done_q, done_d, timeout_q, timeout_d, err_q, err_d;
    logic            c_ram_wen_q, c_ram_wen_d, c_rf_we_q, c_rf_we_d;
    logic [11:0]     c_ram_addr_q, c_ram_addr_d;
    logic [31:0]     c_ram_din_q, c_ram_din_d, c_rf_wdata_q, c_rf_wdata_d;
    logic [4:0]      c_rf_rd_q, c_rf_rd_d;
    logic [7:0]      idx_inc;
    logic            done_hit;

    assign idx_inc  = {1'b0, idx_q} + 8'd1;
    assign done_hit = run_q && bus.cpu_mwe && (bus.cpu_maddr == DONE_ADDR);

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        shift_d      = shift_q;
        idx_d        = idx_q;
        cyc_d        = cyc_q;
        run_d        = 1'b0;
        done_d       = done_q;
        timeout_d    = timeout_q;
        err_d        = err_q;
        c_ram_wen_d  = 1'b0;
        c_ram_addr_d = '0;
        c_ram_din_d  = '0;
        c_rf_we_d    = 1'b0;
        c_rf_rd_d    = '0;
        c_rf_wdata_d = '0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    if (mode_valid(bus.mode)) begin
                        mode_d    = bus.mode;
                        shift_d   = bus.shift_amt;
                        idx_d     = '0;
                        done_d    = 1'b0;
                        timeout_d = 1'b0;
                        err_d     = 1'b0;
                        state_d   = StLoad;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StLoad: begin
                if (bus.ch_valid) begin
                    c_ram_wen_d  = 1'b1;
                    c_ram_addr_d = BaseAddr + {5'b0, idx_q};
                    c_ram_din_d  = {24'b0, bus.ch_data};
                    idx_d        = idx_inc[6:0];
                    if (bus.ch_last || (idx_q == IdxLast)) begin
                        state_d = (idx_inc < 8'(BUF_LEN)) ? StFill : StShift;
                    end
                end
            end
            StFill: begin
                c_ram_wen_d  = 1'b1;
                c_ram_addr_d = BaseAddr + {5'b0, idx_q};
                if (idx_q == IdxLast) begin
                    state_d = StShift;
                end else begin
                    idx_d = idx_inc[6:0];
                end
            end
            StShift: begin
                c_rf_we_d    = 1'b1;
                c_rf_rd_d    = SHIFT_REG;
                c_rf_wdata_d = {27'b0, shift_q};
                cyc_d        = '0;
                state_d      = StRun;
            end
            StRun: begin
                // First RUN cycle still shows the registered shift write; processor released after.
                if (!run_q) begin
                    run_d = 1'b1;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                    if (done_hit) begin
                        done_d  = 1'b1;
                        state_d = StFin;
                    end else if (cyc_q == CycLast) begin
                        timeout_d = 1'b1;
                        state_d   = StFin;
                    end else begin
                        run_d = 1'b1;
                    end
                end
            end
            StFin: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (!reset_ni) begin
            state_q      <= StIdle;
            mode_q       <= '0;
            shift_q      <= '0;
            idx_q        <= '0;
            cyc_q        <= '0;
            run_q        <= 1'b0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
            err_q        <= 1'b0;
            c_ram_wen_q  <= 1'b0;
            c_ram_addr_q <= '0;
            c_ram_din_q  <= '0;
            c_rf_we_q    <= 1'b0;
            c_rf_rd_q    <= '0;
            c_rf_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            shift_q      <= shift_d;
            idx_q        <= idx_d;
            cyc_q        <= cyc_d;
            run_q        <= run_d;
            done_q       <= done_d;
            timeout_q    <= timeout_d;
            err_q        <= err_d;
            c_ram_wen_q  <= c_ram_wen_d;
            c_ram_addr_q <= c_ram_addr_d;
            c_ram_din_q  <= c_ram_din_d;
            c_rf_we_q    <= c_rf_we_d;
            c_rf_rd_q    <= c_rf_rd_d;
            c_rf_wdata_q <= c_rf_wdata_d;
        end
    end

    port_arbiter u_port_arbiter (
        .in_run_i      (run_q),
        .ctl_ram_wen_i (c_ram_wen_q),
        .ctl_ram_addr_i(c_ram_addr_q),
        .ctl_ram_din_i (c_ram_din_q),
        .ctl_rf_we_i   (c_rf_we_q),
        .ctl_rf_rd_i   (c_rf_rd_q),
        .ctl_rf_wdata_i(c_rf_wdata_q),
        .cpu_mwe_i     (bus.cpu_mwe),
        .cpu_maddr_i   (bus.cpu_maddr),
        .cpu_mdata_i   (bus.cpu_mdata),
        .cpu_rwe_i     (bus.cpu_rwe),
        .cpu_rd_i      (bus.cpu_rd),
        .cpu_rdata_i   (bus.cpu_rdata),
        .ram_wen_o     (bus.ram_wen),
        .ram_addr_o    (bus.ram_addr),
        .ram_din_o     (bus.ram_din),
        .rf_we_o       (bus.rf_we),
        .rf_rd_o       (bus.rf_rd),
        .rf_wdata_o    (bus.rf_wdata)
    );

    assign bus.ch_ready    = (state_q == StLoad);
    assign bus.busy        = (state_q != StIdle);
    assign bus.done        = done_q;
    assign bus.timeout     = timeout_q;
    assign bus.err         = err_q;
    assign bus.cpu_reset   = !run_q;
    assign bus.program_sel = run_q ? mode_q : 2'b00;

endmodule

// File: tb/tb_decrypt_job_ctrl.sv
// Directed bench for decrypt_job_ctrl: load, zero-fill, shift injection, run, done/timeout, reset.
module tb_decrypt_job_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    logic [31:0] ram_model [0:4095];

    decrypt_job_ctrl_if bus ();

    decrypt_job_ctrl #(
        .BUF_BASE  (1500),
        .BUF_LEN   (108),
        .DONE_ADDR (12'hFFF),
        .MAX_CYCLES(50)
    ) dut (
        .clock_i (clk),
        .reset_ni(rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.ram_wen === 1'b1) ram_model[bus.ram_addr] <= bus.ram_din;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ch_ready"}, 32'(bus.ch_ready), 32'd0);
        check({tag, "_ram_wen"}, 32'(bus.ram_wen), 32'd0);
        check({tag, "_ram_addr"}, 32'(bus.ram_addr), 32'd0);
        check({tag, "_ram_din"}, bus.ram_din, 32'd0);
        check({tag, "_rf_we"}, 32'(bus.rf_we), 32'd0);
        check({tag, "_rf_rd"}, 32'(bus.rf_rd), 32'd0);
        check({tag, "_rf_wdata"}, bus.rf_wdata, 32'd0);
        check({tag, "_cpu_reset"}, 32'(bus.cpu_reset), 32'd1);
        check({tag, "_program_sel"}, 32'(bus.program_sel), 32'd0);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_done"}, 32'(bus.done), 32'd0);
        check({tag, "_timeout"}, 32'(bus.timeout), 32'd0);
        check({tag, "_err"}, 32'(bus.err), 32'd0);
    endtask

    initial begin
        int bad;
        int cnt;
        int guard;

        for (int a = 0; a < 4096; a++) ram_model[a] = 32'hFFFF_FFFF;
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.mode      = 2'b00;
        bus.shift_amt = 5'd0;
        bus.ch_valid  = 1'b0;
        bus.ch_data   = 8'h00;
        bus.ch_last   = 1'b0;
        bus.cpu_mwe   = 1'b0;
        bus.cpu_maddr = 12'h000;
        bus.cpu_mdata = 32'h0;
        bus.cpu_rwe   = 1'b0;
        bus.cpu_rd    = 5'd0;
        bus.cpu_rdata = 32'h0;
        tick();
        tick();
        check_reset_outputs("por");
        rst_n = 1'b1;
        tick();

        // Idle ignores ch_valid and processor writes; invalid mode raises err.
        bus.ch_valid = 1'b1;
        bus.cpu_mwe  = 1'b1;
        bus.cpu_maddr = 12'h100;
        tick();
        check("idle_ch_ready", 32'(bus.ch_ready), 32'd0);
        check("idle_ram_wen", 32'(bus.ram_wen), 32'd0);
        bus.ch_valid = 1'b0;
        bus.cpu_mwe  = 1'b0;
        bus.start = 1'b1;
        bus.mode  = 2'b11;
        tick();
        bus.start = 1'b0;
        check("bad_mode_err", 32'(bus.err), 32'd1);
        check("bad_mode_busy", 32'(bus.busy), 32'd0);
        tick();
        check("bad_mode_still_idle", 32'(bus.ch_ready), 32'd0);

        // Full 108-byte block, EN, shift 3; a second start mid-load must be ignored.
        bus.start     = 1'b1;
        bus.mode      = 2'b01;
        bus.shift_amt = 5'd3;
        tick();
        bus.start = 1'b0;
        check("load_err_cleared", 32'(bus.err), 32'd0);
        check("load_busy", 32'(bus.busy), 32'd1);
        check("load_ch_ready", 32'(bus.ch_ready), 32'd1);
        bad = 0;
        for (int i = 0; i < 108; i++) begin
            bus.ch_valid = 1'b1;
            bus.ch_data  = 8'(8'h41 + i);
            bus.ch_last  = (i == 107);
            bus.start    = (i == 2);
            bus.mode     = (i == 2) ? 2'b10 : 2'b01;
            bus.shift_amt = (i == 2) ? 5'd9 : 5'd3;
            tick();
            if (bus.ram_wen !== 1'b1 || bus.ram_addr !== 12'(1500 + i) ||
                bus.ram_din !== 32'(8'h41 + i)) bad++;
        end
        bus.ch_valid = 1'b0;
        bus.ch_last  = 1'b0;
        bus.start    = 1'b0;
        check("full_write_seq_bad", 32'(bad), 32'd0);
        check("full_last_addr", 32'(bus.ram_addr), 32'd1607);
        check("full_ready_drop", 32'(bus.ch_ready), 32'd0);
        check("full_no_rf_yet", 32'(bus.rf_we), 32'd0);
        tick();
        check("full_shift_we", 32'(bus.rf_we), 32'd1);
        check("full_shift_rd", 32'(bus.rf_rd), 32'd6);
        check("full_shift_data", bus.rf_wdata, 32'd3);
        check("full_shift_cpu_rst", 32'(bus.cpu_reset), 32'd1);
        check("full_shift_no_ram", 32'(bus.ram_wen), 32'd0);
        tick();
        check("full_run_cpu_rst", 32'(bus.cpu_reset), 32'd0);
        check("full_run_prog", 32'(bus.program_sel), 32'd1);
        bad = 0;
        for (int a = 1500; a < 1608; a++) if (ram_model[a] !== 32'(8'h41 + (a - 1500))) bad++;
        check("full_ram_contents_bad", 32'(bad), 32'd0);

        // Passthrough is combinational in RUN.
        bus.cpu_rwe   = 1'b1;
        bus.cpu_rd    = 5'd9;
        bus.cpu_rdata = 32'h1234;
        bus.cpu_mwe   = 1'b1;
        bus.cpu_maddr = 12'h123;
        bus.cpu_mdata = 32'hDEAD;
        #1;
        check("pass_rf_we", 32'(bus.rf_we), 32'd1);
        check("pass_rf_rd", 32'(bus.rf_rd), 32'd9);
        check("pass_ram_addr", 32'(bus.ram_addr), 32'h123);
        check("pass_ram_din", bus.ram_din, 32'hDEAD);
        bus.cpu_rwe = 1'b0;
        bus.cpu_mwe = 1'b0;

        // Timeout after exactly 50 released cycles.
        cnt = 0;
        guard = 0;
        while (bus.timeout !== 1'b1 && guard < 200) begin
            if (bus.cpu_reset === 1'b0) cnt++;
            guard++;
            tick();
        end
        check("to_run_cycles", 32'(cnt), 32'd50);
        check("to_flag", 32'(bus.timeout), 32'd1);
        check("to_done", 32'(bus.done), 32'd0);
        check("to_fin_cpu_rst", 32'(bus.cpu_reset), 32'd1);
        check("to_fin_prog", 32'(bus.program_sel), 32'd0);
        check("to_fin_busy", 32'(bus.busy), 32'd1);
        tick();
        check("to_idle_busy", 32'(bus.busy), 32'd0);
        check("to_flag_hold", 32'(bus.timeout), 32'd1);

        // Short block, BF, shift 0: zero-fill of 1505..1607.
        bus.start     = 1'b1;
        bus.mode      = 2'b10;
        bus.shift_amt = 5'd0;
        tick();
        bus.start = 1'b0;
        check("short_timeout_cleared", 32'(bus.timeout), 32'd0);
        for (int i = 0; i < 5; i++) begin
            bus.ch_valid = 1'b1;
            bus.ch_data  = 8'(8'h61 + i);
            bus.ch_last  = (i == 4);
            tick();
        end
        bus.ch_valid = 1'b0;
        bus.ch_last  = 1'b0;
        check("short_last_addr", 32'(bus.ram_addr), 32'd1504);
        check("short_last_din", bus.ram_din, 32'h65);
        check("short_ready_drop", 32'(bus.ch_ready), 32'd0);
        bad = 0;
        for (int k = 0; k < 103; k++) begin
            tick();
            if (bus.ram_wen !== 1'b1 || bus.ram_addr !== 12'(1505 + k) ||
                bus.ram_din !== 32'd0) bad++;
        end
        check("fill_seq_bad", 32'(bad), 32'd0);
        tick();
        check("short_shift_we", 32'(bus.rf_we), 32'd1);
        check("short_shift_rd", 32'(bus.rf_rd), 32'd6);
        check("short_shift_zero", bus.rf_wdata, 32'd0);
        check("short_no_ram", 32'(bus.ram_wen), 32'd0);
        tick();
        check("short_run_prog", 32'(bus.program_sel), 32'd2);
        check("short_run_cpu_rst", 32'(bus.cpu_reset), 32'd0);
        bad = 0;
        for (int a = 1505; a < 1608; a++) if (ram_model[a] !== 32'd0) bad++;
        check("short_ram_zero_bad", 32'(bad), 32'd0);
        check("short_ram_head", ram_model[1502], 32'h63);

        // Done store at run cycle 40 (observing run cycle 1 now).
        repeat (39) tick();
        check("done_still_running", 32'(bus.cpu_reset), 32'd0);
        bus.cpu_mwe   = 1'b1;
        bus.cpu_maddr = 12'hFFF;
        bus.cpu_mdata = 32'h1;
        #1;
        check("done_store_forwarded", 32'(bus.ram_addr), 32'hFFF);
        tick();
        bus.cpu_mwe = 1'b0;
        check("done_flag", 32'(bus.done), 32'd1);
        check("done_no_timeout", 32'(bus.timeout), 32'd0);
        check("done_fin_cpu_rst", 32'(bus.cpu_reset), 32'd1);
        check("done_fin_prog", 32'(bus.program_sel), 32'd0);
        check("done_fin_busy", 32'(bus.busy), 32'd1);
        check("done_ram_model", ram_model[12'hFFF], 32'h1);
        tick();
        check("done_idle_busy", 32'(bus.busy), 32'd0);
        check("done_hold", 32'(bus.done), 32'd1);

        // Reset mid-fill at idx=60, then a fresh job from idx 0.
        bus.start     = 1'b1;
        bus.mode      = 2'b01;
        bus.shift_amt = 5'd5;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.ch_valid = 1'b1;
            bus.ch_data  = 8'(8'h20 + i);
            bus.ch_last  = (i == 9);
            tick();
        end
        bus.ch_valid = 1'b0;
        bus.ch_last  = 1'b0;
        repeat (50) tick();
        check("mid_fill_addr", 32'(bus.ram_addr), 32'd1559);
        rst_n = 1'b0;
        tick();
        check_reset_outputs("midrst");
        rst_n = 1'b1;
        tick();
        bus.start     = 1'b1;
        bus.mode      = 2'b01;
        bus.shift_amt = 5'd7;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.ch_valid = 1'b1;
            bus.ch_data  = 8'(8'h10 + i);
            bus.ch_last  = (i == 2);
            tick();
            check("rerun_addr", 32'(bus.ram_addr), 32'(1500 + i));
            check("rerun_din", bus.ram_din, 32'(8'h10 + i));
        end
        bus.ch_valid = 1'b0;
        bus.ch_last  = 1'b0;
        tick();
        check("rerun_fill_addr", 32'(bus.ram_addr), 32'd1503);
        check("rerun_fill_din", bus.ram_din, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
